rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/hdlc_pkg.sv | 15 +
 rtl/rx_frame_buffer.sv | 30 +++
 rtl/rx_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive frame controller.
package hdlc_pkg;

  localparam int RX_BUF_DEPTH = 128;
  localparam int RX_MIN_FRAME = 4;
  localparam int RX_ADDR_W    = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_OVFL  = 2'd2,
    ST_READY = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_frame_buffer.sv
// 128x8 receive frame store: one synchronous write port, one registered read port.
module rx_frame_buffer
  import hdlc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic [RX_ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]           wr_data_i,
  input  logic                 rd_en_i,
  input  logic [RX_ADDR_W-1:0] rd_addr_i,
  output logic [7:0]           rd_data_o
);

  logic [7:0] mem [RX_BUF_DEPTH];
  logic [7:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= 8'd0;
    else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rx_frame_ctrl.sv
// HDLC receive frame controller: collects de-stuffed bytes between flags and hands frames to the host.
// Define HDLC_RX_FCS_STRIP_EN to hide the trailing 2 FCS bytes from the reported frame size.
module rx_frame_ctrl
  import hdlc_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx_Enable,
  input  logic       Rx_FlagDetect,
  input  logic       Rx_AbortDetect,
  input  logic       Rx_NewByte,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_RdBuff,
  input  logic       Rx_Drop,
  output logic       Rx_ValidFrame,
  output logic       Rx_WrBuff,
  output logic       Rx_AbortSignal,
  output logic       Rx_Overflow,
  output logic       Rx_FrameError,
  output logic       Rx_Ready,
  output logic [7:0] Rx_FrameSize,
  output logic [7:0] Rx_DataOut
);

  localparam logic [7:0] DEPTH8 = 8'(RX_BUF_DEPTH);
  localparam logic [7:0] MIN8   = 8'(RX_MIN_FRAME);

  rx_state_e            state_q, state_d;
  logic [7:0]           count_q, count_d, cnt_eff, host_size;
  logic [RX_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic                 wr_buff_q, wr_buff_d, abort_q, abort_d;
  logic                 ovfl_q, ovfl_d, ferr_q, ferr_d;
  logic                 wr_en, rd_en;

`ifdef HDLC_RX_FCS_STRIP_EN
  assign host_size = (count_q > 8'd2) ? count_q - 8'd2 : 8'd0;
`else
  assign host_size = count_q;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_buff_d = 1'b0;
    abort_d   = 1'b0;
    ovfl_d    = ovfl_q;
    ferr_d    = ferr_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    cnt_eff   = count_q;
    if (!Rx_Enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (Rx_FlagDetect) begin
            state_d  = ST_RECV;
            count_d  = 8'd0;
            rd_ptr_d = '0;
            ovfl_d   = 1'b0;
            ferr_d   = 1'b0;
          end
        end
        ST_RECV: begin
          if (Rx_AbortDetect) begin
            abort_d = 1'b1;
            count_d = 8'd0;
            state_d = ST_IDLE;
          end else begin
            if (Rx_NewByte) begin
              if (count_q < DEPTH8) begin
                wr_en     = 1'b1;
                wr_buff_d = 1'b1;
                cnt_eff   = count_q + 8'd1;
                count_d   = cnt_eff;
              end else begin
                ovfl_d  = 1'b1;
                state_d = ST_OVFL;
              end
            end
            // A flag in the same cycle as a byte is judged against the post-store count.
            if (Rx_FlagDetect) begin
              if (cnt_eff >= MIN8) begin
                state_d = ST_READY;
              end else if (cnt_eff != 8'd0) begin
                ferr_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_OVFL: begin
          if (Rx_AbortDetect) begin
            abort_d = 1'b1;
            count_d = 8'd0;
            state_d = ST_IDLE;
          end else if (Rx_FlagDetect) begin
            state_d = ST_READY;
          end
        end
        ST_READY: begin
          if (Rx_Drop) begin
            state_d = ST_IDLE;
          end else if (Rx_RdBuff) begin
            rd_en    = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            if ({1'b0, rd_ptr_q} == host_size - 8'd1) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      count_q   <= 8'd0;
      rd_ptr_q  <= '0;
      wr_buff_q <= 1'b0;
      abort_q   <= 1'b0;
      ovfl_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_buff_q <= wr_buff_d;
      abort_q   <= abort_d;
      ovfl_q    <= ovfl_d;
      ferr_q    <= ferr_d;
    end
  end

  rx_frame_buffer u_buf (
    .clk       (Clk),
    .rst_n     (Rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (count_q[RX_ADDR_W-1:0]),
    .wr_data_i (Rx_Data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (Rx_DataOut)
  );

  assign Rx_ValidFrame  = (state_q == ST_RECV) || (state_q == ST_OVFL);
  assign Rx_Ready       = (state_q == ST_READY);
  assign Rx_WrBuff      = wr_buff_q;
  assign Rx_AbortSignal = abort_q;
  assign Rx_Overflow    = ovfl_q;
  assign Rx_FrameError  = ferr_q;
  assign Rx_FrameSize   = host_size;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: directed scenarios plus random frames against a frame-level model.
module tb_rx_frame_ctrl;

`ifdef HDLC_RX_FCS_STRIP_EN
  localparam int FCS = 2;
`else
  localparam int FCS = 0;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Rx_Enable = 1'b0, Rx_FlagDetect = 1'b0, Rx_AbortDetect = 1'b0;
  logic       Rx_NewByte = 1'b0, Rx_RdBuff = 1'b0, Rx_Drop = 1'b0;
  logic [7:0] Rx_Data = 8'd0;
  logic       Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow, Rx_FrameError, Rx_Ready;
  logic [7:0] Rx_FrameSize, Rx_DataOut;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int abort_cnt = 0;

  rx_frame_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Rx_Enable(Rx_Enable), .Rx_FlagDetect(Rx_FlagDetect),
    .Rx_AbortDetect(Rx_AbortDetect), .Rx_NewByte(Rx_NewByte), .Rx_Data(Rx_Data),
    .Rx_RdBuff(Rx_RdBuff), .Rx_Drop(Rx_Drop), .Rx_ValidFrame(Rx_ValidFrame),
    .Rx_WrBuff(Rx_WrBuff), .Rx_AbortSignal(Rx_AbortSignal), .Rx_Overflow(Rx_Overflow),
    .Rx_FrameError(Rx_FrameError), .Rx_Ready(Rx_Ready), .Rx_FrameSize(Rx_FrameSize),
    .Rx_DataOut(Rx_DataOut)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Rx_WrBuff)      wr_cnt    <= wr_cnt + 1;
    if (Rx_AbortSignal) abort_cnt <= abort_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic flag();
    Rx_FlagDetect = 1'b1;
    step();
    Rx_FlagDetect = 1'b0;
  endtask

  task automatic abort();
    Rx_AbortDetect = 1'b1;
    step();
    Rx_AbortDetect = 1'b0;
  endtask

  // Optional idle gap first, so callers can check immediately after the strobe edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int g = 0; g < gap; g++) step();
    Rx_NewByte = 1'b1;
    Rx_Data    = b;
    step();
    Rx_NewByte = 1'b0;
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp);
    Rx_RdBuff = 1'b1;
    step();
    Rx_RdBuff = 1'b0;
    check(tag, 32'(Rx_DataOut), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {26'd0, Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow,
                           Rx_FrameError, Rx_Ready}, 32'd0);
    check({tag, "_size"}, 32'(Rx_FrameSize), 32'd0);
    check({tag, "_dout"}, 32'(Rx_DataOut), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] held;
    int w0, a0, n, stored;

    // Reset state
    #2;
    check_all_zero("reset");
    step();
    Rst = 1'b1;
    Rx_Enable = 1'b1;
    step();
    check_all_zero("post_reset");

    // Basic frame 0x11..0x16
    w0 = wr_cnt;
    flag();
    check("basic_valid", 32'(Rx_ValidFrame), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), 0);
    check("basic_wr_pulse", 32'(Rx_WrBuff), 32'd1);
    flag();
    check("basic_writes", 32'(wr_cnt - w0), 32'd6);
    check("basic_ready", 32'(Rx_Ready), 32'd1);
    check("basic_valid_off", 32'(Rx_ValidFrame), 32'd0);
    check("basic_size", 32'(Rx_FrameSize), 32'(6 - FCS));
    for (int i = 0; i < 6 - FCS; i++) read_byte("basic_rd", 8'h11 + 8'(i));
    check("basic_idle", 32'(Rx_Ready), 32'd0);

    // Abort after 3 bytes; also abort beats a simultaneous byte
    w0 = wr_cnt;
    a0 = abort_cnt;
    flag();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 2);
    Rx_NewByte = 1'b1;
    abort();
    Rx_NewByte = 1'b0;
    check("abort_pulse", 32'(Rx_AbortSignal), 32'd1);
    check("abort_valid", 32'(Rx_ValidFrame), 32'd0);
    step();
    check("abort_pulse_end", 32'(Rx_AbortSignal), 32'd0);
    check("abort_ready", 32'(Rx_Ready), 32'd0);
    check("abort_count", 32'(abort_cnt - a0), 32'd1);
    check("abort_writes", 32'(wr_cnt - w0), 32'd3);

    // Overflow: 130 bytes then flag
    w0 = wr_cnt;
    flag();
    for (int i = 1; i <= 130; i++) begin
      send_byte(8'(i), 0);
      if (i == 128) check("ovfl_b128", 32'(Rx_Overflow), 32'd0);
      if (i == 129) check("ovfl_b129", 32'(Rx_Overflow), 32'd1);
    end
    check("ovfl_valid", 32'(Rx_ValidFrame), 32'd1);
    flag();
    check("ovfl_writes", 32'(wr_cnt - w0), 32'd128);
    check("ovfl_ready", 32'(Rx_Ready), 32'd1);
    check("ovfl_size", 32'(Rx_FrameSize), 32'(128 - FCS));
    read_byte("ovfl_rd0", 8'd1);
    Rx_Drop = 1'b1;
    step();
    Rx_Drop = 1'b0;
    check("ovfl_drop", 32'(Rx_Ready), 32'd0);
    check("ovfl_sticky", 32'(Rx_Overflow), 32'd1);

    // Short frame error, enable-low keeps sticky flag, next flag clears it
    flag();
    check("ovfl_cleared", 32'(Rx_Overflow), 32'd0);
    send_byte(8'hA1, 1);
    send_byte(8'hA2, 1);
    flag();
    check("ferr_set", 32'(Rx_FrameError), 32'd1);
    check("ferr_ready", 32'(Rx_Ready), 32'd0);
    check("ferr_valid", 32'(Rx_ValidFrame), 32'd0);
    flag();
    send_byte(8'h55, 0);
    a0 = abort_cnt;
    Rx_Enable = 1'b0;
    step();
    check("en_low_valid", 32'(Rx_ValidFrame), 32'd0);
    check("en_low_sticky", 32'(Rx_FrameError), 32'd0);
    Rx_Enable = 1'b1;
    step();
    check("en_low_no_abort", 32'(abort_cnt - a0), 32'd0);
    flag();
    send_byte(8'h01, 0);
    flag();
    check("ferr_again", 32'(Rx_FrameError), 32'd1);
    Rx_Enable = 1'b0;
    flag();
    check("en_low_hold_ferr", 32'(Rx_FrameError), 32'd1);
    check("en_low_ignore_flag", 32'(Rx_ValidFrame), 32'd0);
    Rx_Enable = 1'b1;
    flag();
    check("ferr_cleared", 32'(Rx_FrameError), 32'd0);

    // Shared flag at count 0 stays in frame; byte+flag same cycle at count 3 closes a 4-byte frame
    flag();
    check("shared_flag", 32'(Rx_ValidFrame), 32'd1);
    q.delete();
    for (int i = 0; i < 3; i++) begin
      q.push_back(8'($urandom));
      send_byte(q[i], 1);
    end
    q.push_back(8'hC4);
    Rx_NewByte = 1'b1;
    Rx_Data = 8'hC4;
    flag();
    Rx_NewByte = 1'b0;
    check("byteflag_ready", 32'(Rx_Ready), 32'd1);
    check("byteflag_size", 32'(Rx_FrameSize), 32'(4 - FCS));

    // Drop and read together: drop wins, output data unchanged
    read_byte("drop_rd0", q[0]);
    held = Rx_DataOut;
    Rx_Drop = 1'b1;
    Rx_RdBuff = 1'b1;
    step();
    Rx_Drop = 1'b0;
    Rx_RdBuff = 1'b0;
    check("drop_idle", 32'(Rx_Ready), 32'd0);
    step();
    check("drop_dout", 32'(Rx_DataOut), 32'(held));
    flag();
    check("ready_was_left", 32'(Rx_ValidFrame), 32'd1);
    abort();

    // Random frames against the frame-level model
    for (int f = 0; f < 16; f++) begin
      n = int'($urandom_range(140, 1));
      q.delete();
      w0 = wr_cnt;
      flag();
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (i < 128) q.push_back(b);
        send_byte(b, 1);
      end
      flag();
      stored = (n > 128) ? 128 : n;
      check("rnd_writes", 32'(wr_cnt - w0), 32'(stored));
      check("rnd_ovfl", 32'(Rx_Overflow), 32'(n > 128));
      check("rnd_ferr", 32'(Rx_FrameError), 32'(n < 4));
      check("rnd_ready", 32'(Rx_Ready), 32'(n >= 4));
      if (n >= 4) begin
        check("rnd_size", 32'(Rx_FrameSize), 32'(stored - FCS));
        if ($urandom_range(3, 0) == 0) begin
          read_byte("rnd_rd_partial", q[0]);
          Rx_Drop = 1'b1;
          step();
          Rx_Drop = 1'b0;
        end else begin
          for (int i = 0; i < stored - FCS; i++) read_byte("rnd_rd", q[i]);
        end
        check("rnd_done", 32'(Rx_Ready), 32'd0);
      end
    end

    // Reset mid-frame after 10 bytes; later bytes without a flag are ignored
    flag();
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
    step();
    Rst = 1'b0;
    #1;
    check_all_zero("midreset");
    step();
    Rst = 1'b1;
    step();
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
    step();
    check("midreset_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("midreset_valid", 32'(Rx_ValidFrame), 32'd0);
    Rx_FlagDetect = 1'b1;
    Rx_AbortDetect = 1'b1;
    step();
    Rx_FlagDetect = 1'b0;
    Rx_AbortDetect = 1'b0;
    check("idle_abort_ignored", 32'(Rx_AbortSignal), 32'd0);
    check("idle_flag_opens", 32'(Rx_ValidFrame), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
